// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_pkg
//  Description : Shared FSM state encoding and default parameter constants
//                for the keypad scanner block.
//  Revision    : 1.0  - initial release
// ============================================================================
package keypad_pkg;

    localparam int c_def_n_keys        = 10;
    localparam int c_def_deb_cycles    = 16;
    localparam int c_def_repeat_cycles = 1024;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESS_DEB = 2'd1,
        HOLD      = 2'd2,
        REL_DEB   = 2'd3
    } state_t;

endpackage : keypad_pkg
`default_nettype wire

// File: rtl/keypad_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_debounce
//  Description : Stability tracker. Holds a reference pattern and counts how
//                many consecutive samples have matched it. A restart, or any
//                sample that differs, re-latches the reference and clears the
//                count. 'stable' flags the sample that completes a run of
//                DEB_CYCLES matches after the latching sample.
//  Revision    : 1.0  - initial release
// ============================================================================
module keypad_debounce #(
    parameter int W          = 10,
    parameter int DEB_CYCLES = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] sample,
    input  logic         restart,
    output logic         match,
    output logic         stable
);

    localparam int c_cnt_w = $clog2(DEB_CYCLES + 1);

    logic [W-1:0]       r_ref;
    logic [c_cnt_w-1:0] r_cnt;

    assign match  = (sample == r_ref);
    assign stable = match && (r_cnt >= c_cnt_w'(DEB_CYCLES - 1));

    // Reference latch and saturating run-length counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ref <= '0;
            r_cnt <= '0;
        end else if (restart || !match) begin
            r_ref <= sample;
            r_cnt <= '0;
        end else if (r_cnt != c_cnt_w'(DEB_CYCLES)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule : keypad_debounce
`default_nettype wire

// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_scanner
//  Description : Debounced one-hot keypad encoder with valid/ready output,
//                multi-key error and overrun pulses.
//                Optional feature macro: KEYPAD_AUTOREPEAT_EN - re-emits the
//                held single key every REPEAT_CYCLES clocks.
//  Revision    : 1.0  - initial release
// ============================================================================
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int N_KEYS        = c_def_n_keys,
    parameter int CODE_W        = $clog2(N_KEYS),
    parameter int DEB_CYCLES    = c_def_deb_cycles,
    parameter int REPEAT_CYCLES = c_def_repeat_cycles
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] keypad,
    input  logic              enablen,
    output logic [CODE_W-1:0] code,
    output logic              valid_data,
    input  logic              ready,
    output logic              multi_err,
    output logic              overrun
);

    generate
        if (N_KEYS < 2 || N_KEYS > 64 || DEB_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_bad_params
            $error("keypad_scanner: parameter out of range");
        end
    endgenerate

    logic [N_KEYS-1:0] r_sync1;
    logic [N_KEYS-1:0] r_sync2;
    state_t            r_state;
    logic [CODE_W-1:0] r_code;
    logic              r_valid;
    logic              r_multi_err;
    logic              r_overrun;

    logic [N_KEYS-1:0] w_sample;
    logic              w_restart;
    logic              w_match;
    logic              w_stable;
    logic              w_multi;
    logic              w_single;
    logic [CODE_W-1:0] w_index;
    logic              w_eval;
    logic              w_rep_fire;
    logic              w_emit;

    // Two-flop synchronizer on the raw key lines
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= keypad;
            r_sync2 <= r_sync1;
        end
    end

    assign w_sample = r_sync2;

    // IDLE re-latches every sample so the first nonzero one starts a run;
    // scan disable also holds the counter cleared.
    assign w_restart = enablen || (r_state == IDLE);

    keypad_debounce #(
        .W          (N_KEYS),
        .DEB_CYCLES (DEB_CYCLES)
    ) u_debounce (
        .clk     (clk),
        .rst     (rst),
        .sample  (w_sample),
        .restart (w_restart),
        .match   (w_match),
        .stable  (w_stable)
    );

    // Clearing the lowest set bit leaves something only if two or more are set
    assign w_multi  = |(w_sample & (w_sample - N_KEYS'(1)));
    assign w_single = (w_sample != '0) && !w_multi;

    // Binary index of the set bit; meaningful only when w_single
    always_comb begin
        w_index = '0;
        for (int i = 0; i < N_KEYS; i++) begin
            if (w_sample[i]) begin
                w_index = CODE_W'(i);
            end
        end
    end

    // One evaluation per debounced press
    assign w_eval = !enablen && (r_state == PRESS_DEB) && (w_sample != '0) && w_stable;

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int c_rep_w = $clog2(REPEAT_CYCLES + 1);

    logic [c_rep_w-1:0] r_rep_cnt;

    assign w_rep_fire = !enablen && (r_state == HOLD) && w_match && w_single &&
                        (r_rep_cnt == c_rep_w'(REPEAT_CYCLES - 1));

    // Repeat period counter; runs only while a single key is held steady
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rep_cnt <= '0;
        end else if (enablen || (r_state != HOLD) || !w_match || !w_single || w_rep_fire) begin
            r_rep_cnt <= '0;
        end else if (r_rep_cnt != c_rep_w'(REPEAT_CYCLES - 1)) begin
            r_rep_cnt <= r_rep_cnt + 1'b1;
        end
    end
`else
    assign w_rep_fire = 1'b0;
`endif

    assign w_emit = (w_eval && w_single) || w_rep_fire;

    // Scan FSM with registered code, handshake and error pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_code      <= '0;
            r_valid     <= 1'b0;
            r_multi_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_multi_err <= 1'b0;
            r_overrun   <= 1'b0;

            if (r_valid && ready) begin
                r_valid <= 1'b0;
            end

            // A pending, unaccepted code wins over a new one
            if (w_emit) begin
                if (r_valid && !ready) begin
                    r_overrun <= 1'b1;
                end else begin
                    r_code  <= w_index;
                    r_valid <= 1'b1;
                end
            end

            if (w_eval && w_multi) begin
                r_multi_err <= 1'b1;
            end

            if (enablen) begin
                r_state <= IDLE;
            end else begin
                unique case (r_state)
                    IDLE: begin
                        if (w_sample != '0) begin
                            r_state <= PRESS_DEB;
                        end
                    end
                    PRESS_DEB: begin
                        if (w_sample == '0) begin
                            r_state <= IDLE;
                        end else if (w_stable) begin
                            r_state <= HOLD;
                        end
                    end
                    HOLD: begin
                        if (!w_match) begin
                            r_state <= REL_DEB;
                        end
                    end
                    REL_DEB: begin
                        if (w_stable && (w_sample == '0)) begin
                            r_state <= IDLE;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign code       = r_code;
    assign valid_data = r_valid;
    assign multi_err  = r_multi_err;
    assign overrun    = r_overrun;

endmodule : keypad_scanner
`default_nettype wire

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL have parameter N_KEYS, default 10, meaning the number of one-hot key lines (2..64).
REQ-002 SHALL have parameter CODE_W, default $clog2(N_KEYS), meaning the output code width.
REQ-003 SHALL have parameter DEB_CYCLES, default 16, meaning the consecutive stable samples required for a press or release (>=2).
REQ-004 SHALL have parameter REPEAT_CYCLES, default 1024, meaning the auto-repeat period, used only under KEYPAD_AUTOREPEAT_EN.
REQ-005 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1, reset that is asynchronous and active-high.
REQ-007 SHALL have port keypad, input, N_KEYS, raw asynchronous key lines, active-high.
REQ-008 SHALL have port enablen, input, 1, active-low scan enable.
REQ-009 SHALL have port code, output, CODE_W, binary index of the pressed key.
REQ-010 SHALL have port valid_data, output, 1, meaning code is valid.
REQ-011 SHALL have port ready, input, 1, consumer acceptance.
REQ-012 SHALL have port multi_err, output, 1, one-cycle pulse when more than one key is stably pressed.
REQ-013 SHALL have port overrun, output, 1, one-cycle pulse when a press is dropped because the output is still occupied.

Function
REQ-014 SHALL pass keypad through a 2-flop synchronizer before any other use.
REQ-015 SHALL use FSM states IDLE, PRESS_DEB, HOLD, REL_DEB.
REQ-016 IDLE: on any nonzero synchronized pattern, SHALL latch that pattern, clear the counter and go to PRESS_DEB.
REQ-017 PRESS_DEB: a sample differing from the latched pattern SHALL re-latch it and restart the counter; an all-zero sample SHALL return the FSM to IDLE.
REQ-018 PRESS_DEB: after DEB_CYCLES consecutive equal samples, SHALL go to HOLD and evaluate the pattern once.
REQ-019 The evaluation SHALL load code with the key index and set valid_data if exactly one bit is set; if two or more bits are set, it SHALL pulse multi_err and SHALL NOT load code.
REQ-020 Latency from a clean single-key edge to valid_data high SHALL be exactly DEB_CYCLES+3 clk edges.
REQ-021 valid_data/code handshake: a transfer SHALL occur on a cycle with valid_data && ready; valid_data SHALL clear on the next edge unless a new code is loaded in that same cycle.
REQ-022 code SHALL remain stable while valid_data && !ready.
REQ-023 If valid_data is still high when an evaluation would load a code, the new code SHALL be discarded and overrun SHALL pulse; the pending code SHALL remain unchanged.
REQ-024 HOLD: a change of pattern, including all-zero, SHALL go to REL_DEB with the counter cleared.
REQ-025 REL_DEB: DEB_CYCLES consecutive all-zero samples SHALL lead to IDLE; a nonzero sample SHALL restart the counter; no new code SHALL be emitted until IDLE is reached.
REQ-026 While enablen is high, the FSM SHALL be forced to IDLE on the next edge with the counters cleared, and no new code SHALL be emitted; a pending valid_data SHALL still complete its handshake.
REQ-027 Counters SHALL saturate, never wrap.

Reset
REQ-028 On rst high, the synchronizer, FSM (IDLE), counters, code (0), valid_data (0), multi_err (0) and overrun (0) SHALL clear immediately, including mid-debounce and with a pending code.
REQ-029 After rst deasserts, a key already held SHALL be debounced as a new press.

Configuration
REQ-030 With KEYPAD_AUTOREPEAT_EN defined, HOLD on a single key SHALL re-emit the same code every REPEAT_CYCLES cycles, subject to REQ-023.
REQ-031 Without KEYPAD_AUTOREPEAT_EN, the block SHALL emit exactly one code per press and SHALL NOT synthesize the repeat counter.

Structure
REQ-032 The package keypad_pkg SHALL hold the FSM state enum and the default parameter constants.
REQ-033 The stability counter and compare logic SHALL be the sub-module keypad_debounce (inputs: sample, restart; output: stable).

Verification (N_KEYS=10, DEB_CYCLES=4, ready=1 unless stated)
REQ-034 keypad=0x008 held for 20 cycles -> code=3 and valid_data high for 1 cycle at edge 7; no repeat.
REQ-035 keypad=0x008 with a glitch to 0x000 on cycle 3 -> no output until 4 stable samples after the glitch.
REQ-036 keypad=0x201 held -> multi_err pulses once, valid_data stays 0.
REQ-037 ready=0, press key 5, release, then press key 2 -> code stays 5, overrun pulses once; code=5 transfers when ready=1.
REQ-038 rst pulse during PRESS_DEB and enablen=1 during a hold -> all outputs 0 and the FSM in IDLE; with KEYPAD_AUTOREPEAT_EN and REPEAT_CYCLES=8, key 1 held -> code=1 every 8 cycles.
